uart_reg_responder: RTL and testbench
=====================================

// Module: uart_reg_responder
// PURPOSE
//  Byte-frame command responder on the CPU side of the UART top (rd/r_empty/r_data, wr/w_data/t_full).
//  Pops command frames from the RX FIFO, executes reads/writes on a local byte register file,
//  and pushes a one-byte response into the TX FIFO. Gives a host PC register access over the serial line.
// PARAMETERS
//  DATA_BITS   8      byte width; must match the UART DATA_BITS
//  ADDR_W      3      register file address bits; depth = 2**ADDR_W
//  TMO_W       16     inter-byte timeout counter width
//  TMO_MAX     50000  idle cycles allowed between bytes of one frame; 0 disables the timeout
// PORTS
//  clk        in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-low reset
//  rd         out  1          RX FIFO pop strobe
//  r_empty    in   1          RX FIFO empty
//  r_data     in   DATA_BITS  RX FIFO head byte, valid while r_empty=0
//  wr         out  1          TX FIFO push strobe
//  w_data     out  DATA_BITS  response byte, valid while wr=1
//  t_full     in   1          TX FIFO full
//  reg0_out   out  DATA_BITS  live copy of register 0, for control use
//  busy       out  1          1 whenever state != IDLE
//  frame_err  out  1          1-cycle pulse on any rejected or aborted frame
// BEHAVIOUR
//  Frame: CMD, ADDR [, DATA]. CMD 0x57 'W' = write; CMD 0x52 'R' = read.
//  Responses: write OK -> 0x4B 'K'; read OK -> reg[ADDR]; bad CMD or ADDR >= 2**ADDR_W -> 0x3F '?'.
//  FSM states: IDLE, GET_ADDR, GET_DATA, EXEC, SEND.
//   - IDLE --byte--> GET_ADDR. Any CMD value is accepted; it is validated in EXEC.
//   - GET_ADDR --byte--> GET_DATA if CMD='W', otherwise EXEC.
//   - GET_DATA --byte--> EXEC.
//   - EXEC (1 cycle) -> SEND.
//   - SEND --wr--> IDLE.
//  Pop rule, IDLE and GET_* states:
//   - If r_empty=0: rd=1 for exactly one cycle; r_data is captured on that edge; state advances on that edge.
//   - rd is never high while r_empty=1. Back-to-back pops are allowed.
//  EXEC:
//   - Valid write: reg[ADDR] <= DATA.
//   - Response byte is registered into w_data. Invalid frame: no register change, frame_err=1 this cycle.
//  SEND:
//   - wr=1 for one cycle on the first cycle with t_full=0. While t_full=1, hold with wr=0 and w_data stable.
//   - No RX pops occur in EXEC or SEND.
//  Latency: last pop at cycle N -> EXEC at N+1 -> wr at N+2 (if t_full=0).
//  Timeout, GET_ADDR/GET_DATA only:
//   - Counter clears on each pop and counts cycles with r_empty=1.
//   - At TMO_MAX: -> IDLE, frame discarded, no response, frame_err pulse, counter cleared.
//   - TMO_MAX=0: never times out.
//  Address byte: the full DATA_BITS value is compared against 2**ADDR_W; there is no silent truncation.
//  Write then read of the same address in consecutive frames returns the new value.
//  Reset, asynchronous, any state: state=IDLE, all regs=0, rd=0, wr=0, w_data=0, busy=0, frame_err=0,
//   reg0_out=0, timeout counter=0. A partial frame is discarded. Bytes already in the FIFOs are untouched.
// CONFIGURATION
//  Macro UART_RESP_CSUM_EN, optional checksum check.
//  Defined:
//   - Extra state GET_CSUM after the last payload byte; it obeys the pop and timeout rules.
//   - CSUM must equal XOR of all prior frame bytes.
//   - Mismatch -> response 0x21 '!', no register write, frame_err pulse.
//   - Checksum is checked before CMD/ADDR validity; mismatch takes precedence.
//   - Latency counts from the CSUM pop.
//  Undefined: no GET_CSUM state; frames are exactly as above.
// TESTING
//  1. W frame 57 02 A5, then R frame 52 02
//     -> responses 4B then A5; reg0_out stays 00.
//  2. W frame 57 00 3C
//     -> reg0_out=3C one cycle after EXEC; wr exactly 2 cycles after the 3C pop.
//  3. Frame 52 09 (ADDR_W=3); then CMD 55
//     -> 3F with frame_err pulse for each; no register change.
//  4. t_full=1 for 10 cycles during SEND
//     -> wr held low, w_data stable, exactly one wr after release; rd=0 throughout.
//  5. Bytes 57 01, then silence for TMO_MAX cycles
//     -> frame_err, IDLE, no wr; next frame 52 01 -> 00.
//  6. Reset low mid-GET_DATA
//     -> all outputs 0 immediately, state IDLE; with UART_RESP_CSUM_EN, 57 01 11 47 -> 4B and 57 01 11 00 -> 21.

Source files
------------

// File: rtl/uart_reg_responder.sv
// uart_reg_responder: serial command frames (CMD, ADDR [, DATA]) to byte register file access.
// Define UART_RESP_CSUM_EN to require a trailing XOR checksum byte on every frame.
module uart_reg_responder #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_W    = 3,
    parameter int TMO_W     = 16,
    parameter int TMO_MAX   = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 rd,
    input  logic                 r_empty,
    input  logic [DATA_BITS-1:0] r_data,
    output logic                 wr,
    output logic [DATA_BITS-1:0] w_data,
    input  logic                 t_full,
    output logic [DATA_BITS-1:0] reg0_out,
    output logic                 busy,
    output logic                 frame_err
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [DATA_BITS-1:0] CMD_W    = DATA_BITS'(8'h57);
    localparam logic [DATA_BITS-1:0] CMD_R    = DATA_BITS'(8'h52);
    localparam logic [DATA_BITS-1:0] RSP_OK   = DATA_BITS'(8'h4B);
    localparam logic [DATA_BITS-1:0] RSP_BAD  = DATA_BITS'(8'h3F);
`ifdef UART_RESP_CSUM_EN
    localparam logic [DATA_BITS-1:0] RSP_CSUM = DATA_BITS'(8'h21);
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, GET_CSUM, EXEC, SEND} state_t;
    localparam state_t AFTER_PAYLOAD = GET_CSUM;
`else
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC, SEND} state_t;
    localparam state_t AFTER_PAYLOAD = EXEC;
`endif
    state_t state, next;
    logic [DATA_BITS-1:0] cmd_q, addr_q, data_q, resp;
    logic [DATA_BITS-1:0] regs [DEPTH];
    logic [TMO_W-1:0] tmo_cnt;
    logic in_frame, tmo_hit, csum_ok, cmd_ok, addr_ok, ok;
`ifdef UART_RESP_CSUM_EN
    logic [DATA_BITS-1:0] acc, csum_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        in_frame = state != IDLE && state != EXEC && state != SEND;
        rd = reset && !r_empty && (state == IDLE || in_frame);
        tmo_hit = (TMO_MAX != 0) && in_frame && r_empty && tmo_cnt == TMO_W'(TMO_MAX - 1);
`ifdef UART_RESP_CSUM_EN
        csum_ok = csum_q == acc;
`else
        csum_ok = 1'b1;
`endif
        cmd_ok = cmd_q == CMD_W || cmd_q == CMD_R;
        // full byte compared so out-of-range addresses never alias onto a real register
        addr_ok = int'(addr_q) < DEPTH;
        ok = csum_ok && cmd_ok && addr_ok;
        resp = !csum_ok ? `ifdef UART_RESP_CSUM_EN RSP_CSUM `else RSP_BAD `endif
             : !(cmd_ok && addr_ok) ? RSP_BAD
             : cmd_q == CMD_W ? RSP_OK : regs[addr_q[ADDR_W-1:0]];
        case (state)
            IDLE:     next = rd ? GET_ADDR : IDLE;
            GET_ADDR: next = tmo_hit ? IDLE : !rd ? GET_ADDR : cmd_q == CMD_W ? GET_DATA : AFTER_PAYLOAD;
            GET_DATA: next = tmo_hit ? IDLE : rd ? AFTER_PAYLOAD : GET_DATA;
`ifdef UART_RESP_CSUM_EN
            GET_CSUM: next = tmo_hit ? IDLE : rd ? EXEC : GET_CSUM;
`endif
            EXEC:     next = SEND;
            SEND:     next = t_full ? SEND : IDLE;
            default:  next = IDLE;
        endcase
        wr = state == SEND && !t_full;
        busy = state != IDLE;
        frame_err = tmo_hit || (state == EXEC && !ok);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            w_data <= '0;
            tmo_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
`ifdef UART_RESP_CSUM_EN
            acc <= '0;
            csum_q <= '0;
`endif
        end else begin
            tmo_cnt <= (in_frame && r_empty && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
            if (rd) begin
                if (state == IDLE) cmd_q <= r_data;
                if (state == GET_ADDR) addr_q <= r_data;
                if (state == GET_DATA) data_q <= r_data;
`ifdef UART_RESP_CSUM_EN
                if (state == GET_CSUM) csum_q <= r_data;
                else acc <= state == IDLE ? r_data : acc ^ r_data;
`endif
            end
            if (state == EXEC) begin
                w_data <= resp;
                if (ok && cmd_q == CMD_W) regs[addr_q[ADDR_W-1:0]] <= data_q;
            end
        end
    end

    assign reg0_out = regs[0];
endmodule

// File: tb/tb_uart_reg_responder.sv
// tb_uart_reg_responder: FIFO-model bench with a response scoreboard for uart_reg_responder.
module tb_uart_reg_responder;
    localparam int TMO = 20;
`ifdef UART_RESP_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    logic clk = 0, reset = 0, r_empty = 1, t_full = 0;
    logic rd, wr, busy, frame_err;
    logic [7:0] r_data = 0, w_data, reg0_out, wr_reg0 = 0;
    logic [7:0] rx_q[$], exp_q[$];
    int checks = 0, failures = 0, cyc = 0, fe_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    int last_pop = 0, last_wr = 0, rd_bad = 0, unexp = 0, f0, w0, r0, bad;

    uart_reg_responder #(.DATA_BITS(8), .ADDR_W(3), .TMO_W(16), .TMO_MAX(TMO)) dut (
        .clk(clk), .reset(reset), .rd(rd), .r_empty(r_empty), .r_data(r_data),
        .wr(wr), .w_data(w_data), .t_full(t_full), .reg0_out(reg0_out),
        .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void upd();
        r_empty = rx_q.size() == 0;
        r_data = r_empty ? 8'h00 : rx_q[0];
    endfunction

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        upd();
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp);
        push(c);
        push(a);
        if (c == 8'h57) push(d);
`ifdef UART_RESP_CSUM_EN
        push(c ^ a ^ (c == 8'h57 ? d : 8'h00));
`endif
        exp_q.push_back(exp);
    endtask

    // sample at negedge, let the DUT consume on posedge, then update the RX FIFO model
    task automatic step();
        logic g_rd, g_wr;
        logic [7:0] g_w;
        @(negedge clk);
        g_rd = rd; g_wr = wr; g_w = w_data; cyc++;
        if (rd && r_empty) rd_bad++;
        if (frame_err) fe_cnt++;
        if (g_rd) begin rd_cnt++; last_pop = cyc; end
        if (g_wr) begin
            wr_cnt++; last_wr = cyc; wr_reg0 = reg0_out;
            if (exp_q.size() == 0) unexp++;
            else check("resp", 32'(g_w), 32'(exp_q.pop_front()));
        end
        @(posedge clk); #1;
        if (g_rd && rx_q.size() != 0) void'(rx_q.pop_front());
        upd();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || rx_q.size() != 0 || busy) && n < 200) begin
            step();
            n++;
        end
        check({tag, "_done"}, 32'(n < 200), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {28'b0, rd, wr, busy, frame_err}, 0);
        check("rst_wdata", 32'(w_data), 0);
        check("rst_reg0", 32'(reg0_out), 0);
        reset = 1;
        frame(8'h57, 8'h02, 8'hA5, 8'h4B);
        frame(8'h52, 8'h02, 8'h00, 8'hA5);
        drain("t1");
        check("t1_reg0", 32'(reg0_out), 0);
        frame(8'h57, 8'h00, 8'h3C, 8'h4B);
        drain("t2");
        check("t2_latency", last_wr - last_pop, 2);
        check("t2_reg0_at_wr", 32'(wr_reg0), 32'h3C);
        f0 = fe_cnt;
        frame(8'h52, 8'h09, 8'h00, 8'h3F);
        frame(8'h55, 8'h02, 8'h00, 8'h3F);
        frame(8'h57, 8'h0A, 8'h77, 8'h3F);
        frame(8'h52, 8'h08, 8'h00, 8'h3F);
        frame(8'h52, 8'h07, 8'h00, 8'h00);
        frame(8'h52, 8'h02, 8'h00, 8'hA5);
        drain("t3");
        check("t3_ferr", fe_cnt - f0, 4);
        t_full = 1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        frame(8'h52, 8'h02, 8'h00, 8'hA5);
        repeat (6) step();
        check("t4_pops", rd_cnt - r0, 2 + CS);
        r0 = rd_cnt;
        bad = 0;
        repeat (10) begin
            step();
            if (w_data !== 8'hA5) bad++;
        end
        check("t4_wr_held", wr_cnt - w0, 0);
        check("t4_no_rd", rd_cnt - r0, 0);
        check("t4_wdata_stable", bad, 0);
        check("t4_busy", 32'(busy), 1);
        t_full = 0;
        drain("t4");
        check("t4_one_wr", wr_cnt - w0, 1);
        f0 = fe_cnt;
        w0 = wr_cnt;
        push(8'h57);
        push(8'h01);
        repeat (2 + TMO - 1) step();
        check("t5_busy_before", 32'(busy), 1);
        check("t5_no_early_err", fe_cnt - f0, 0);
        step();
        check("t5_ferr", fe_cnt - f0, 1);
        check("t5_idle", 32'(busy), 0);
        check("t5_no_wr", wr_cnt - w0, 0);
        frame(8'h52, 8'h01, 8'h00, 8'h00);
        drain("t5");
        frame(8'h52, 8'h00, 8'h00, 8'h3C);
        drain("t6_pre");
        push(8'h57);
        push(8'h03);
        repeat (3) step();
        check("t6_busy_pre", 32'(busy), 1);
        reset = 0;
        #1;
        check("t6_rst_ctl", {28'b0, rd, wr, busy, frame_err}, 0);
        check("t6_rst_wdata", 32'(w_data), 0);
        check("t6_rst_reg0", 32'(reg0_out), 0);
        @(posedge clk);
        #1;
        reset = 1;
        frame(8'h52, 8'h03, 8'h00, 8'h00);
        frame(8'h52, 8'h02, 8'h00, 8'h00);
        drain("t6");
`ifdef UART_RESP_CSUM_EN
        f0 = fe_cnt;
        push(8'h57); push(8'h01); push(8'h11); push(8'h47);
        exp_q.push_back(8'h4B);
        push(8'h57); push(8'h01); push(8'h22); push(8'h00);
        exp_q.push_back(8'h21);
        frame(8'h52, 8'h01, 8'h00, 8'h11);
        drain("t7");
        check("t7_ferr", fe_cnt - f0, 1);
`endif
        check("unexpected_wr", unexp, 0);
        check("rd_while_empty", rd_bad, 0);
        check("exp_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
